// File: rtl/ram_uart_loader.sv
// ram_uart_loader: turns a UART byte stream into 32-bit RAM writes.
// Frame = 16-bit word count N (LSB first) followed by N little-endian words.
// Words land at BASE_ADDR, BASE_ADDR+1, ... on RAM port A.
// Optional feature macro LOADER_VERIFY_EN: read back each word after writing
// it and abort the load on a mismatch. Without it douta is ignored.
//
// Byte handshake: a byte moves on a rising clka edge where rx_valid and
// rx_ready are both high. rx_ready depends only on the current state, so the
// sender may hold rx_valid high indefinitely; the byte is not consumed until
// rx_ready is seen high on the same edge.
module ram_uart_loader #(
  parameter int ADDR_W    = 20,
  parameter int DEPTH     = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              wea,
  input  logic [47:0]       douta,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR0  = 4'd1;
  localparam logic [3:0] S_HDR1  = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_WRITE = 4'd4;
`ifdef LOADER_VERIFY_EN
  localparam logic [3:0] S_VRD   = 4'd5;
  localparam logic [3:0] S_VCMP  = 4'd6;
`endif
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  // 17 bits so that the largest header (0xFFFF) compares correctly against DEPTH.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [3:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [31:0]       dina_q, dina_d;
  logic              wea_q, wea_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [15:0]       words_q, words_d;

  logic [15:0]       hdr_n;
  logic [31:0]       word_next;
  logic [15:0]       words_inc;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_douta;

`ifdef LOADER_VERIFY_EN
  assign unused_douta = ^douta[47:32];
`else
  assign unused_douta = ^douta;
`endif

  // Address of the word about to be written: base plus index, wrapped to ADDR_W.
  assign word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(words_q);
  assign words_inc = words_q + 16'd1;

  // Byte acceptance is a pure decode of the current state.
  assign rx_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);

  assign addra        = addra_q;
  assign dina         = dina_q;
  assign wea          = wea_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

  // Next-state and output-register computation for the load sequence.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    words_d    = words_q;
    hdr_n      = {rx_data, n_q[7:0]};
    word_next  = word_q;
    word_next[{byte_idx_q, 3'b000} +: 8] = rx_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = 16'd0;
        end
      end

      S_HDR0: begin
        if (rx_valid) begin
          n_d[7:0] = rx_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (rx_valid) begin
          n_d[15:8] = rx_data;
          if (hdr_n == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if ({1'b0, hdr_n} > DEPTH_L) begin
            // Oversized image is rejected before any RAM write.
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          word_d = word_next;
          if (byte_idx_q == 2'd3) begin
            // Register the write so wea is high exactly while in WRITE.
            state_d    = S_WRITE;
            byte_idx_d = 2'd0;
            wea_d      = 1'b1;
            addra_d    = word_addr;
            dina_d     = word_next;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        words_d = words_inc;
`ifdef LOADER_VERIFY_EN
        state_d = S_VRD;
`else
        if (words_inc < n_q) begin
          state_d = S_DATA;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
`endif
      end

`ifdef LOADER_VERIFY_EN
      S_VRD: begin
        // addra still holds the written address; RAM returns it next cycle.
        state_d = S_VCMP;
      end

      S_VCMP: begin
        if (douta[31:0] != dina_q) begin
          state_d = S_ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (words_q < n_q) begin
          state_d = S_DATA;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      addra_q    <= '0;
      dina_q     <= 32'd0;
      wea_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
    end
  end

endmodule

// File: tb/tb_ram_uart_loader.sv
// Testbench for ram_uart_loader: random frames against a frame-level model
// that predicts the list of RAM writes and the final status flags.
module tb_ram_uart_loader;

  localparam int ADDR_W    = 20;
  localparam int DEPTH     = 128;
  localparam int BASE_ADDR = 0;
  localparam int W         = ADDR_W + 32;
  localparam int CORRUPT_IDX = 1;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  logic rst_n;
  always #5 clka = ~clka;

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              wea;
  logic [47:0]       douta;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;
  logic [3:0]        dbg_state;

  ram_uart_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clka(clka), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .addra(addra), .dina(dina),
    .wea(wea), .douta(douta), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] mem [0:255];
  logic        corrupt = 1'b0;
  always @(posedge clka) begin
    if (wea) mem[addra[7:0]] <= dina;
    douta <= {16'hBEEF, mem[addra[7:0]] ^
              ((corrupt && addra == ADDR_W'(BASE_ADDR + CORRUPT_IDX)) ? 32'h0000_0100 : 32'h0)};
  end

  // ---------------- scoreboard ----------------
  int n_compared   = 0;
  int n_mismatched = 0;
  int write_count  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the next predicted {addr, data}.
  always @(negedge clka) begin
    if (rst_n === 1'b1 && wea === 1'b1) begin
      write_count++;
      if (exp_q.size() == 0) check("unexpected_wea", 1, 0);
      else check("ram_write", {addra, dina}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(posedge clka); #1;
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 0, 1);
    @(posedge clka); #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clka); #1; end
  endtask

  // mode: 0 random words, 1 word i = i, 2 fixed two-word image.
  task automatic run_frame(input int n, input int mode, input bit gaps,
                           input bit poke_start, input bit corrupt_on);
    logic [31:0] words[$];
    logic [15:0] nn;
    int nwr;
    bit exp_err;
    int t;
    nn = 16'(n);
    // Frame-level model of the loader.
    if (n == 0)          begin nwr = 0; exp_err = 1'b0; end
    else if (n > DEPTH)  begin nwr = 0; exp_err = 1'b1; end
    else if (corrupt_on && n > CORRUPT_IDX) begin nwr = CORRUPT_IDX + 1; exp_err = 1'b1; end
    else                 begin nwr = n; exp_err = 1'b0; end
    for (int i = 0; i < nwr; i++) begin
      if (mode == 1)      words.push_back(32'(i));
      else if (mode == 2) words.push_back(i == 0 ? 32'h1122_3344 : 32'hAABB_CCDD);
      else                words.push_back($urandom());
      exp_q.push_back({ADDR_W'(BASE_ADDR + i), words[i]});
    end

    pulse_start();
    check("busy_after_start", busy, 1);
    check("cleared_after_start", {done, error, words_loaded}, 0);
    send_byte(nn[7:0]);
    gap(gaps);
    send_byte(nn[15:8]);

    if (n == 0) begin
      check("empty_done_next_cycle", done, 1);
      // start arriving while in DONE is dropped
      pulse_start();
      check("start_in_done_ignored", {busy, done}, 2'b01);
    end

    for (int i = 0; i < nwr; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (poke_start && i == 0 && k == 1) pulse_start();
        gap(gaps);
        send_byte(words[i][8*k +: 8]);
      end
    end

    t = 0;
    while (!(done || error) && t < 40) begin
      @(posedge clka); #1;
      t++;
    end
    check("end_status", {done, error}, {!exp_err, exp_err});
    check("words_loaded", words_loaded, 16'(nwr));
    check("busy_cleared", busy, 0);
    check("writes_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) begin @(posedge clka); #1; end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int wr_before;
    int wea_hi, rdy_hi;
    start = 0; rx_valid = 0; rx_data = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    check("rst_outputs", {rx_ready, wea, busy, done, error}, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_words", words_loaded, 0);
    rst_n = 1'b1;

    wea_hi = 0; rdy_hi = 0;
    repeat (20) begin
      @(negedge clka);
      if (wea) wea_hi++;
      if (rx_ready) rdy_hi++;
    end
    check("idle_wea_pulses", wea_hi, 0);
    check("idle_rx_ready", rdy_hi, 0);
    @(posedge clka); #1;

    // fixed two-word image, extra start mid-frame
    run_frame(2, 2, 1'b0, 1'b1, 1'b0);
    // full RAM, then one too many, then the largest header
    run_frame(DEPTH, 1, 1'b0, 1'b0, 1'b0);
    run_frame(DEPTH + 1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'hFFFF, 0, 1'b1, 1'b0, 1'b0);
    // empty image
    run_frame(0, 0, 1'b0, 1'b0, 1'b0);

    // reset after 6 data bytes of a two-word frame
    wr_before = write_count;
    exp_q.push_back({ADDR_W'(BASE_ADDR), 32'h0403_0201});
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    for (int k = 1; k <= 6; k++) send_byte(8'(k));
    repeat (3) begin @(posedge clka); #1; end
    rst_n = 1'b0;
    #1;
    check("midload_write_count", write_count - wr_before, 1);
    check("midload_reset_outputs", {rx_ready, wea, busy, done, error}, 0);
    check("midload_reset_words", words_loaded, 0);
    check("midload_reset_addra", addra, 0);
    check("midload_writes_drained", exp_q.size(), 0);
    @(posedge clka); #1;
    rst_n = 1'b1;
    @(posedge clka); #1;
    run_frame(2, 0, 1'b1, 1'b0, 1'b0);

    // random frames
    for (int r = 0; r < 8; r++)
      run_frame($urandom_range(1, 12), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    run_frame(DEPTH, 0, 1'b1, 1'b0, 1'b0);

`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_frame(3, 0, 1'b0, 1'b0, 1'b1);
    corrupt = 1'b0;
    run_frame(3, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
